// File: rtl/uart_tx_fifo_ctrl.sv
// UART TX sequencer: pops bytes from the TX FIFO and hands each one to the serializer, with flush and an inter-frame gap.
// Latency: launch condition seen in IDLE at cycle N -> tx_start/fifo_rd high at N+1; done at M -> next start at M+2 (no gap).
// Backpressure: frames launch only with en=1, cts_n=0 and a non-empty FIFO; a launched frame holds until tx_done_tick.
module uart_tx_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_TICKS  = 16,
    parameter int GAP_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  cts_n,
    input  logic                  flush,
    input  logic                  s_tick,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_din,
    input  logic                  tx_done_tick,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    // Terminal gap count; unused when GAP_TICKS is 0 because GAP is never entered.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS == 0) ? '0 : GAP_W'(GAP_TICKS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             launch_ok;

    // en and cts_n only gate new frames; they are never looked at once a frame is launched.
    assign launch_ok = en && !cts_n && !fifo_empty;

    // State register; reset drops any frame in flight back to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over launch in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (launch_ok) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (s_tick && (gap_cnt == GAP_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (fifo_empty && !flush) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; LAUNCH is a registered state so start/pop there are glitch-free single-cycle pulses.
    always_comb begin
        tx_start = 1'b0;
        fifo_rd  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            LAUNCH: begin
                tx_start = 1'b1;
                fifo_rd  = 1'b1;
            end
            FLUSH: begin
                fifo_rd = !fifo_empty;
            end
            default: begin
                tx_start = 1'b0;
                fifo_rd  = 1'b0;
            end
        endcase
    end

    // Datapath: byte capture at launch, completed-frame count, inter-frame gap count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_din    <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if ((state == IDLE) && !flush && launch_ok) begin
                tx_din <= fifo_r_data;
            end
            if ((state == WAIT_DONE) && tx_done_tick) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                gap_cnt   <= '0;
            end
            if ((state == GAP) && s_tick) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: default instance (gap 16) plus a CNT_W=4, GAP_TICKS=0 instance.
// Latency: all checks taken 1 time unit after the rising edge.
// Backpressure: a small FIFO level model pops on the selected instance's fifo_rd.
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       en_b = 1'b0;
    logic       cts_n = 1'b1;
    logic       flush = 1'b0;
    logic       s_tick = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_r_data = 8'h00;
    logic       tx_done_tick = 1'b0;

    logic        fifo_rd_a, tx_start_a, busy_a;
    logic [7:0]  tx_din_a;
    logic [15:0] frame_cnt_a;
    logic        fifo_rd_b, tx_start_b, busy_b;
    logic [7:0]  tx_din_b;
    logic [3:0]  frame_cnt_b;

    int   total = 0;
    int   bad = 0;
    int   level = 0;
    int   load_val = 0;
    logic load = 1'b0;
    logic clr = 1'b0;
    logic use_b = 1'b0;
    int   starts = 0;
    int   pops = 0;
    logic fifo_rd_sel;

    uart_tx_fifo_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .cts_n(cts_n), .flush(flush),
        .s_tick(s_tick), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
        .fifo_rd(fifo_rd_a), .tx_start(tx_start_a), .tx_din(tx_din_a),
        .tx_done_tick(tx_done_tick), .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .GAP_TICKS(0), .GAP_W(8), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .cts_n(cts_n), .flush(flush),
        .s_tick(s_tick), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
        .fifo_rd(fifo_rd_b), .tx_start(tx_start_b), .tx_din(tx_din_b),
        .tx_done_tick(tx_done_tick), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    always #5 clk = ~clk;

    assign fifo_rd_sel = use_b ? fifo_rd_b : fifo_rd_a;
    assign fifo_empty  = (level == 0);

    // FIFO occupancy: direct load from the stimulus, else one pop per fifo_rd cycle.
    always @(posedge clk) begin
        if (load) begin
            level <= load_val;
        end else if (fifo_rd_sel && (level != 0)) begin
            level <= level - 1;
        end
    end

    // Event counters for the main instance.
    always @(posedge clk) begin
        if (clr) begin
            starts <= 0;
            pops   <= 0;
        end else begin
            if (tx_start_a) starts <= starts + 1;
            if (fifo_rd_a)  pops   <= pops + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_load(input int n);
        load_val = n;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic gap_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick = 1'b1;
            cyc();
            s_tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        int got;

        // 1: reset held 2 cycles with every input active
        reset_n = 1'b0; en = 1'b1; en_b = 1'b1; cts_n = 1'b0; flush = 1'b1;
        s_tick = 1'b1; tx_done_tick = 1'b1; fifo_r_data = 8'hFF;
        fifo_load(3);
        cyc();
        chk("rst_busy", busy_a, 0);
        chk("rst_tx_start", tx_start_a, 0);
        chk("rst_fifo_rd", fifo_rd_a, 0);
        chk("rst_tx_din", tx_din_a, 0);
        chk("rst_frame_cnt", frame_cnt_a, 0);
        chk("rst_busy_b", busy_b, 0);
        en = 1'b0; en_b = 1'b0; cts_n = 1'b1; flush = 1'b0; s_tick = 1'b0; tx_done_tick = 1'b0;
        fifo_load(0);
        reset_n = 1'b1;
        cyc();

        // 2: single frame, then 16-tick gap
        fifo_r_data = 8'hA5;
        fifo_load(1);
        en = 1'b1; cts_n = 1'b0;
        cyc();
        chk("t2_start", tx_start_a, 1);
        chk("t2_rd", fifo_rd_a, 1);
        chk("t2_din", tx_din_a, 8'hA5);
        cyc();
        chk("t2_start_1cyc", tx_start_a, 0);
        chk("t2_rd_1cyc", fifo_rd_a, 0);
        chk("t2_busy_wait", busy_a, 1);
        fifo_r_data = 8'h00;
        cyc(); cyc();
        chk("t2_din_stable", tx_din_a, 8'hA5);
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        chk("t2_frame_cnt", frame_cnt_a, 1);
        chk("t2_busy_gap", busy_a, 1);
        gap_ticks(5);
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        chk("t2_done_in_gap", frame_cnt_a, 1);
        gap_ticks(10);
        chk("t2_busy_15ticks", busy_a, 1);
        s_tick = 1'b1;
        cyc();
        s_tick = 1'b0;
        chk("t2_idle_16ticks", busy_a, 0);
        cyc();

        // 3: cts_n held off for 100 cycles
        cts_n = 1'b1;
        fifo_r_data = 8'h3C;
        fifo_load(1);
        clear_counts();
        for (int i = 0; i < 100; i++) cyc();
        chk("t3_no_start", starts, 0);
        chk("t3_idle", busy_a, 0);
        cts_n = 1'b0;
        cyc();
        chk("t3_start", tx_start_a, 1);
        chk("t3_din", tx_din_a, 8'h3C);
        cyc();
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        chk("t3_frame_cnt", frame_cnt_a, 2);
        gap_ticks(16);
        chk("t3_idle_after_gap", busy_a, 0);

        // 4: flush five words from IDLE
        en = 1'b0;
        fifo_load(5);
        clear_counts();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t4_busy_flush", busy_a, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_rd_%0d", i), fifo_rd_a, 1);
            chk($sformatf("t4_nostart_%0d", i), tx_start_a, 0);
            cyc();
        end
        chk("t4_rd_empty", fifo_rd_a, 0);
        cyc();
        chk("t4_idle", busy_a, 0);
        chk("t4_pops", pops, 5);
        chk("t4_starts", starts, 0);
        chk("t4_frame_cnt", frame_cnt_a, 2);

        // 6: reset during WAIT_DONE, then a stale done pulse
        fifo_r_data = 8'h5A;
        fifo_load(1);
        en = 1'b1;
        cyc();
        chk("t6_start", tx_start_a, 1);
        cyc();
        en = 1'b0;
        reset_n = 1'b0;
        cyc();
        chk("t6_rst_idle", busy_a, 0);
        chk("t6_rst_frame_cnt", frame_cnt_a, 0);
        chk("t6_rst_din", tx_din_a, 0);
        reset_n = 1'b1;
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        chk("t6_late_done_cnt", frame_cnt_a, 0);
        chk("t6_late_done_start", tx_start_a, 0);
        cyc();
        chk("t6_still_idle", busy_a, 0);

        // 5: CNT_W=4, no gap, 17 back-to-back frames
        use_b = 1'b1;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        fifo_r_data = 8'hC3;
        fifo_load(20);
        en_b = 1'b1;
        cts_n = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start_b) begin
                got = 1;
                break;
            end
            cyc();
        end
        chk("t5_first_start", got, 1);
        chk("t5_din", tx_din_b, 8'hC3);
        for (int i = 0; i < 17; i++) begin
            cyc();
            tx_done_tick = 1'b1;
            cyc();
            tx_done_tick = 1'b0;
            if (i == 16) en_b = 1'b0;
            chk($sformatf("t5_m1_nostart_%0d", i), tx_start_b, 0);
            cyc();
            chk($sformatf("t5_m2_start_%0d", i), tx_start_b, (i < 16) ? 1 : 0);
        end
        chk("t5_frame_cnt_wrap", frame_cnt_b, 1);
        chk("t5_level", level, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
